// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

  typedef enum logic {
    RR     = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  localparam int DEFAULT_MAX_BURST = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with an optional fixed-winner override for conflicts.
module rr_arb2
  import imem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic force_en,
  input  logic force_port,
  output logic gnt0,
  output logic gnt1
);

  logic winner;

  // A lone requester always wins; on a conflict the override port wins, else the port not served last
  always_comb begin
    winner = force_en ? force_port : ~last_gnt;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (req0 && req1) begin
      gnt0 = (winner == PORT_FETCH);
      gnt1 = (winner == PORT_LOAD);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a fetch port and a loader port onto one single-port instruction memory.
// The loader can lock the memory for bursts; a burst cap forces one fetch slot so fetch never starves.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state;
  logic             last_gnt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_next;
  logic             force_fetch;
  logic             rst_hold;
  logic             arb_en;
  logic             force_en;
  logic             force_port;
  logic             f_aligned;
  logic             l_aligned;

  // Grants are suppressed while reset is high and for one cycle after it releases
  assign arb_en     = !reset && !rst_hold;
  assign force_en   = (state == LOCKED) || force_fetch;
  assign force_port = force_fetch ? PORT_FETCH : PORT_LOAD;
  assign f_aligned  = (f_addr[1:0] == 2'b00);
  assign l_aligned  = (l_addr[1:0] == 2'b00);
  assign burst_next = burst_cnt + CNT_W'(1);

  rr_arb2 u_rr_arb2 (
    .req0       (f_req && arb_en),
    .req1       (l_req && arb_en),
    .last_gnt   (last_gnt),
    .force_en   (force_en),
    .force_port (force_port),
    .gnt0       (f_gnt),
    .gnt1       (l_gnt)
  );

  // Read data is only passed through while the matching valid is high
  assign f_rdata = f_rvalid ? mem_rdata : '0;
  assign l_rdata = l_rvalid ? mem_rdata : '0;

  // Drive the memory strobe only for an accepted aligned request; otherwise the bus is all zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt && f_aligned) begin
      mem_en   = 1'b1;
      mem_addr = f_addr;
    end else if (l_gnt && l_aligned) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  // Lock FSM, burst counter, round-robin history and the one-deep response pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RR;
      last_gnt    <= PORT_LOAD;
      burst_cnt   <= '0;
      force_fetch <= 1'b0;
      rst_hold    <= 1'b1;
      f_rvalid    <= 1'b0;
      f_err       <= 1'b0;
      l_rvalid    <= 1'b0;
      l_err       <= 1'b0;
    end else begin
      rst_hold <= 1'b0;
      f_rvalid <= f_gnt && f_aligned;
      f_err    <= f_gnt && !f_aligned;
      l_rvalid <= l_gnt && l_aligned && !l_we;
      l_err    <= l_gnt && !l_aligned;

      if (f_gnt) begin
        last_gnt    <= PORT_FETCH;
        force_fetch <= 1'b0;
      end else if (l_gnt) begin
        last_gnt <= PORT_LOAD;
      end

      case (state)
        RR: begin
          if (l_gnt && l_lock) begin
            if (burst_next == BURST_MAX) begin
              burst_cnt   <= '0;
              force_fetch <= 1'b1;
            end else begin
              state     <= LOCKED;
              burst_cnt <= burst_next;
            end
          end
        end
        LOCKED: begin
          if (!l_req) begin
            state     <= RR;
            burst_cnt <= '0;
          end else if (l_gnt) begin
            if (!l_lock) begin
              state     <= RR;
              burst_cnt <= '0;
            end else if (burst_next == BURST_MAX) begin
              state       <= RR;
              burst_cnt   <= '0;
              force_fetch <= 1'b1;
            end else begin
              burst_cnt <= burst_next;
            end
          end
        end
        default: begin
          state     <= RR;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule
